// File: rtl/blur_frame_controller.sv
// blur_frame_controller: frames a raster pixel stream for an external blurring
// filter. It latches the kernel code at frame start, tracks row/column, and
// delays each accepted pixel so it lines up with the filter result. Pixels
// inside the kernel-radius border are emitted raw, and all other pixels take
// the filter output.
module blur_frame_controller #(
  parameter int DATA_WIDTH     = 12,
  parameter int IMG_WIDTH      = 320,
  parameter int IMG_HEIGHT     = 240,
  parameter int FILTER_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            freq_flag_req,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_in_valid,
  input  logic                  sof,
  output logic [2:0]            filter_freq_flag,
  output logic [DATA_WIDTH-1:0] filter_data_in,
  input  logic [DATA_WIDTH-1:0] filter_data_out,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_out_valid,
  output logic                  eof_out,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = 4;
  localparam int LL = FILTER_LATENCY;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2} state_t;

  state_t                state, next_state;
  logic [CW-1:0]         col, pos_col, next_col;
  logic [RW-1:0]         row, pos_row, next_row;
  logic [FW-1:0]         flush_cnt;
  logic                  start, abort, accept, last_pix, border;
  logic [2:0]            eff_code;
  logic [31:0]           prow, pcol, rad;
  logic [LL-1:0]         dly_valid, dly_border, dly_eof;
  logic [DATA_WIDTH-1:0] dly_raw [LL];

  // Kernel radius for a kernel code; unknown codes mean no border.
  function automatic logic [1:0] radius_of(input logic [2:0] code);
    logic [1:0] r;
    case (code)
      3'b000:  r = 2'd0;
      3'b010:  r = 2'd1;
      3'b100:  r = 2'd2;
      3'b011:  r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Acceptance, position of the accepted pixel, and the counter advance.
  // A sof pixel is always position (0,0) and uses the code it latches.
  always_comb begin
    start    = (state == IDLE) && pixel_in_valid && sof;
    abort    = (state == ACTIVE) && pixel_in_valid && sof;
    accept   = start || ((state == ACTIVE) && pixel_in_valid);
    pos_col  = sof ? {CW{1'b0}} : col;
    pos_row  = sof ? {RW{1'b0}} : row;
    last_pix = accept && (pos_row == RW'(IMG_HEIGHT - 1)) && (pos_col == CW'(IMG_WIDTH - 1));
    if (last_pix) begin
      next_col = {CW{1'b0}};
      next_row = {RW{1'b0}};
    end else if (pos_col == CW'(IMG_WIDTH - 1)) begin
      next_col = {CW{1'b0}};
      next_row = pos_row + {{(RW-1){1'b0}}, 1'b1};
    end else begin
      next_col = pos_col + {{(CW-1){1'b0}}, 1'b1};
      next_row = pos_row;
    end
    eff_code = sof ? freq_flag_req : filter_freq_flag;
    prow     = 32'(pos_row);
    pcol     = 32'(pos_col);
    rad      = 32'(radius_of(eff_code));
    border   = (prow < rad) || (prow + rad > 32'(IMG_HEIGHT - 1)) ||
               (pcol < rad) || (pcol + rad > 32'(IMG_WIDTH - 1));
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACTIVE; else next_state = IDLE;
      ACTIVE:  if (last_pix) next_state = FLUSH; else next_state = ACTIVE;
      FLUSH:   if (flush_cnt == FW'(LL - 1)) next_state = IDLE; else next_state = FLUSH;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Row/column counters, flush timer, latched kernel code and abort pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col              <= {CW{1'b0}};
      row              <= {RW{1'b0}};
      flush_cnt        <= {FW{1'b0}};
      filter_freq_flag <= 3'b000;
      frame_err        <= 1'b0;
    end else begin
      if (accept) begin
        col <= next_col;
        row <= next_row;
      end
      if (state == FLUSH) flush_cnt <= flush_cnt + {{(FW-1){1'b0}}, 1'b1};
      else                flush_cnt <= {FW{1'b0}};
      if (start || abort) filter_freq_flag <= freq_flag_req;
      frame_err <= abort;
    end
  end

  // Delay line carrying valid, border decision, end-of-frame mark and raw data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_valid  <= {LL{1'b0}};
      dly_border <= {LL{1'b0}};
      dly_eof    <= {LL{1'b0}};
      for (int i = 0; i < LL; i++) dly_raw[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      for (int i = LL - 1; i > 0; i--) begin
        dly_valid[i]  <= dly_valid[i-1];
        dly_border[i] <= dly_border[i-1];
        dly_eof[i]    <= dly_eof[i-1];
        dly_raw[i]    <= dly_raw[i-1];
      end
      dly_valid[0]  <= accept;
      dly_border[0] <= border;
      dly_eof[0]    <= last_pix;
      dly_raw[0]    <= pixel_in;
    end
  end

  // Outputs: pass-through to the filter, raw/filtered select at the tail.
  always_comb begin
    filter_data_in  = pixel_in;
    busy            = (state != IDLE);
    pixel_out_valid = dly_valid[LL-1];
    eof_out         = dly_valid[LL-1] && dly_eof[LL-1];
    if (dly_valid[LL-1]) pixel_out = dly_border[LL-1] ? dly_raw[LL-1] : filter_data_out;
    else                 pixel_out = {DATA_WIDTH{1'b0}};
  end

endmodule

// File: doc/blur_frame_controller.md
BLUR_FRAME_CONTROLLER -- requirements
Module: blur_frame_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 12, pixel width in bits.
REQ-002 Parameter IMG_WIDTH, default 320, pixels per row.
REQ-003 Parameter IMG_HEIGHT, default 240, rows per frame.
REQ-004 Parameter FILTER_LATENCY, default 1, cycles from filter_data_in to filter_data_out; range 1-8.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 freq_flag_req  input  3  requested kernel code; sampled only at frame start.
REQ-008 pixel_in  input  DATA_WIDTH  raster-order input pixel.
REQ-009 pixel_in_valid  input  1  pixel_in is valid this cycle.
REQ-010 sof  input  1  qualifies pixel_in as pixel (0,0); meaningful only with pixel_in_valid.
REQ-011 filter_freq_flag  output  3  kernel code driven to the blurring filter.
REQ-012 filter_data_in  output  DATA_WIDTH  pixel driven to the filter.
REQ-013 filter_data_out  input  DATA_WIDTH  filter result.
REQ-014 pixel_out  output  DATA_WIDTH  output pixel.
REQ-015 pixel_out_valid  output  1  pixel_out is valid.
REQ-016 eof_out  output  1  marks the last output pixel of a frame.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 frame_err  output  1  one-cycle pulse on aborted frame.

Function
REQ-019 The FSM SHALL have states IDLE, ACTIVE and FLUSH.
REQ-020 In IDLE, pixel_in_valid without sof SHALL be ignored (no output, no counting).
REQ-021 IDLE->ACTIVE on pixel_in_valid&&sof; same edge latches freq_flag_req into filter_freq_flag, sets col=1,row=0 (pixel (0,0) is accepted).
REQ-022 filter_freq_flag SHALL hold constant from frame start until the next accepted sof.
REQ-023 Kernel radius R SHALL decode from the latched code: 000->0, 010->1, 100->2, 011->3, any other code->0.
REQ-024 In ACTIVE, each pixel_in_valid SHALL advance col; col wraps IMG_WIDTH-1->0 with row+1; cycles without valid hold counters.
REQ-025 filter_data_in SHALL equal pixel_in combinationally (pass-through) in every state.
REQ-026 Acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1) SHALL move ACTIVE->FLUSH.
REQ-027 FLUSH SHALL last exactly FILTER_LATENCY cycles, ignore pixel_in_valid and sof, then return to IDLE.
REQ-028 Each accepted pixel SHALL produce exactly one pixel_out_valid cycle FILTER_LATENCY cycles after acceptance, via a valid/position/raw-data delay line.
REQ-029 pixel_out SHALL be the delayed raw pixel if its row<R, row>IMG_HEIGHT-1-R, col<R or col>IMG_WIDTH-1-R; otherwise filter_data_out.
REQ-030 eof_out SHALL assert together with pixel_out_valid for pixel (IMG_HEIGHT-1, IMG_WIDTH-1) only.
REQ-031 sof with pixel_in_valid in ACTIVE SHALL abort the frame: pulse frame_err next cycle, relatch freq_flag_req, restart counters treating this pixel as (0,0); delayed outputs of the old frame still emerge, eof_out never asserts for it.
REQ-032 When FILTER_LATENCY=1, a new sof arriving in the single FLUSH cycle SHALL be ignored; upstream guarantees one idle cycle between frames.
REQ-033 Counters SHALL be sized $clog2 of IMG_WIDTH/IMG_HEIGHT; no counter exceeds its bound.

Reset
REQ-034 reset SHALL force, asynchronously: state=IDLE, row=col=0, delay line cleared, filter_freq_flag=000, pixel_out=0, pixel_out_valid=0, eof_out=0, busy=0, frame_err=0.
REQ-035 reset mid-frame SHALL discard all in-flight pixels; no output valid until a new sof is accepted after release.

Verification (IMG_WIDTH=IMG_HEIGHT=10, FILTER_LATENCY=1, filter model = registered data_in+1000)
REQ-036 freq_flag_req=000, 100-pixel frame value=row*10+col with sof on first -> 100 outputs equal row*10+col+1000, eof_out on 100th, busy drops 2 cycles after last input.
REQ-037 freq_flag_req=010 -> border pixels (row/col 0 or 9) output raw, interior (1..8) output value+1000; filter_freq_flag=010 throughout.
REQ-038 freq_flag_req=011, changed to 000 at pixel 50 -> filter_freq_flag stays 011; only rows/cols 3..6 filtered.
REQ-039 sof reasserted at pixel 37 -> frame_err single-cycle pulse, no eof_out for first frame, second frame completes with eof_out after its 100th pixel.
REQ-040 reset asserted at pixel 20 with valid held high -> all outputs 0 immediately; pixels without sof after release produce no pixel_out_valid.
REQ-041 valid deasserted every other cycle -> output count 100, order preserved, each output exactly 1 cycle after its input.
